// File: rtl/orb_pkg.sv
// Shared constants for the keypoint pipeline: XYO word layout, octave tags,
// image geometry defaults and the fetch FSM state type.
package orb_pkg;

  localparam int XYO_W = 22;
  localparam int KP_W  = 37;

  localparam logic [1:0] OCT_L0 = 2'b01;
  localparam logic [1:0] OCT_L1 = 2'b10;

  localparam int X_MSB   = 21;
  localparam int X_LSB   = 12;
  localparam int Y_MSB   = 11;
  localparam int Y_LSB   = 2;
  localparam int OCT_MSB = 1;
  localparam int OCT_LSB = 0;

  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int MARGIN_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/xyo_fetch_if.sv
// Keypoint stream from the XYO fetcher to the descriptor/orientation stage.
interface xyo_fetch_if #(
  parameter int CNT_W = 15
);
  logic             kp_valid;
  logic             kp_ready;
  logic [9:0]       kp_x;
  logic [9:0]       kp_y;
  logic [1:0]       kp_oct;
  logic [CNT_W-1:0] kp_idx;

  modport master (output kp_valid, kp_x, kp_y, kp_oct, kp_idx, input kp_ready);
  modport slave  (input kp_valid, kp_x, kp_y, kp_oct, kp_idx, output kp_ready);
endinterface

// File: rtl/xyo_fetch_kp_fifo.sv
// Small synchronous FIFO holding accepted keypoints; head is read combinationally.
module kp_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/xyo_fetch.sv
// Streams the merged XYO keypoint list, dropping off-window or mis-tagged
// entries, with credit-limited prefetch to hide RAM latency.
module xyo_fetch
  import orb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 15,
  parameter int RD_LAT = 2,
  parameter int DEPTH  = 4,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int MARGIN = MARGIN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_total,
  input  logic [ADDR_W-1:0] num_L1,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [XYO_W-1:0]  rd_data,
  xyo_fetch_if.master       kp,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  num_kept,
  output logic [CNT_W-1:0]  num_drop,
  output logic              err_tag
);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int IF_W = $clog2(RD_LAT+1);
  localparam int CR_W = $clog2(DEPTH+RD_LAT+1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2**ADDR_W);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [9:0] X_LO = 10'(MARGIN);
  localparam logic [9:0] X_HI = 10'(IMG_W - MARGIN);
  localparam logic [9:0] Y_LO = 10'(MARGIN);
  localparam logic [9:0] Y_HI = 10'(IMG_H - MARGIN);

  fetch_state_e      state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] l1;

  logic              pipe_vld [RD_LAT];
  logic [CNT_W-1:0]  pipe_idx [RD_LAT];
  logic [IF_W-1:0]   in_flight;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [KP_W-1:0]   fifo_dout;
  logic [CR_W-1:0]   credit;

  logic              issue, arrive, tag_ok, win_ok, push, drop, pop;
  logic [9:0]        ret_x, ret_y;
  logic [1:0]        ret_oct;
  logic [CNT_W-1:0]  ret_idx;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + IF_W'(pipe_vld[i]);
  end

  // A read is only issued when its word is guaranteed a FIFO slot on return
  assign credit  = CR_W'(fifo_count) + CR_W'(in_flight);
  assign issue   = (state == ST_FETCH) && (credit < CR_W'(DEPTH)) && !fifo_full;
  assign rd_en   = issue;
  assign rd_addr = rd_idx[ADDR_W-1:0];

  // ---- return stage: tag travels RD_LAT cycles to meet rd_data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_vld[i] <= 1'b0;
    end else begin
      pipe_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_idx[0] <= rd_idx;
    for (int i = 1; i < RD_LAT; i++) pipe_idx[i] <= pipe_idx[i-1];
  end

  assign arrive  = pipe_vld[RD_LAT-1];
  assign ret_idx = pipe_idx[RD_LAT-1];
  assign ret_x   = rd_data[X_MSB:X_LSB];
  assign ret_y   = rd_data[Y_MSB:Y_LSB];
  assign ret_oct = rd_data[OCT_MSB:OCT_LSB];

  assign tag_ok = (ret_idx < CNT_W'(l1)) ? (ret_oct == OCT_L0) : (ret_oct == OCT_L1);
  assign win_ok = (ret_x >= X_LO) && (ret_x < X_HI) && (ret_y >= Y_LO) && (ret_y < Y_HI);
  assign push   = arrive && tag_ok && win_ok;
  assign drop   = arrive && !(tag_ok && win_ok);
  assign pop    = kp.kp_valid && kp.kp_ready;

  // ---- control FSM; start clears the run counters after any increment ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      l1       <= '0;
      rd_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      num_kept <= '0;
      num_drop <= '0;
      err_tag  <= 1'b0;
    end else begin
      if (push) num_kept <= num_kept + ONE;
      if (drop) num_drop <= num_drop + ONE;
      if (arrive && !tag_ok) err_tag <= 1'b1;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            cnt      <= (num_total > MAX_CNT) ? MAX_CNT : num_total;
            l1       <= num_L1;
            rd_idx   <= '0;
            num_kept <= '0;
            num_drop <= '0;
            err_tag  <= 1'b0;
            busy     <= 1'b1;
            state    <= (num_total == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            rd_idx <= rd_idx + ONE;
            if (rd_idx == cnt - ONE) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((in_flight == '0) && fifo_empty) state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- output stage: FIFO head, forced to zero when nothing is queued ----
  kp_fifo #(
    .W     (KP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({ret_idx, ret_x, ret_y, ret_oct}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign kp.kp_valid = !fifo_empty;
  assign {kp.kp_idx, kp.kp_x, kp.kp_y, kp.kp_oct} = fifo_empty ? '0 : fifo_dout;

endmodule
